// File: rtl/countdown_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_ctrl
// Sequencing controller for an MM:SS countdown timer. Holds a preset and a
// running count, interprets debounced button pulses (set / start-stop / inc)
// and decrements the count on the 1 Hz tick. All outputs are registered.
//
// Ports:
//   i_clk             system clock (single domain)
//   i_rst             synchronous reset, active-high
//   i_tick            1 Hz one-cycle enable pulse
//   i_btn_mode        one-cycle pulse: cycle edit field / abort run
//   i_btn_start_stop  one-cycle pulse: start, pause or resume
//   i_btn_inc         one-cycle pulse: increment selected field in SET states
//   o_sec_u, o_sec_t  seconds units (BCD 0-9) / tens (0-5)
//   o_min_u, o_min_t  minutes units (BCD 0-9) / tens (0-5)
//   o_edit_sel        00 none, 01 minutes edited, 10 seconds edited
//   o_running         high in RUN
//   o_alarm           high in EXPIRED
// -----------------------------------------------------------------------------
module countdown_ctrl #(
    parameter int ALARM_TICKS = 5,
    parameter int CNT_W       = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_btn_mode,
    input  logic       i_btn_start_stop,
    input  logic       i_btn_inc,
    output logic [3:0] o_sec_u,
    output logic [2:0] o_sec_t,
    output logic [3:0] o_min_u,
    output logic [2:0] o_min_t,
    output logic [1:0] o_edit_sel,
    output logic       o_running,
    output logic       o_alarm
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET_MIN = 3'd1,
        ST_SET_SEC = 3'd2,
        ST_RUN     = 3'd3,
        ST_PAUSE   = 3'd4,
        ST_EXPIRED = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LP_ALARM_TICKS = CNT_W'(ALARM_TICKS);

    // Time layout (14 bits): [13:11] min tens, [10:7] min units,
    //                        [6:4]   sec tens, [3:0]  sec units
    // A 7-bit field is {tens[2:0], units[3:0]} holding 00..59.

    // Increment one 00..59 BCD field, wrapping 59 -> 00.
    function automatic logic [6:0] f_inc_field(input logic [6:0] fld);
        logic [2:0] t;
        logic [3:0] u;
        t = fld[6:4];
        u = fld[3:0];
        if (u == 4'd9) begin
            u = 4'd0;
            if (t == 3'd5) begin
                t = 3'd0;
            end else begin
                t = t + 3'd1;
            end
        end else begin
            u = u + 4'd1;
        end
        return {t, u};
    endfunction

    // Decrement MM:SS by one second with BCD borrows; 00:00 stays 00:00.
    function automatic logic [13:0] f_dec_time(input logic [13:0] c);
        logic [2:0] mt;
        logic [3:0] mu;
        logic [2:0] st;
        logic [3:0] su;
        {mt, mu, st, su} = c;
        if (c == 14'd0) begin
            su = 4'd0;
        end else if (su != 4'd0) begin
            su = su - 4'd1;
        end else begin
            su = 4'd9;
            if (st != 3'd0) begin
                st = st - 3'd1;
            end else begin
                st = 3'd5;
                if (mu != 4'd0) begin
                    mu = mu - 4'd1;
                end else begin
                    mu = 4'd9;
                    mt = mt - 3'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    state_t           r_state;
    logic [13:0]      r_preset;
    logic [13:0]      r_count;
    logic [CNT_W-1:0] r_alarm_cnt;
    logic [13:0]      r_disp;
    logic [1:0]       r_edit_sel;
    logic             r_running;
    logic             r_alarm;

    state_t           w_state_nxt;
    logic [13:0]      w_preset_nxt;
    logic [13:0]      w_count_nxt;
    logic [CNT_W-1:0] w_alarm_cnt_nxt;
    logic [CNT_W-1:0] w_alarm_cnt_inc;
    logic [13:0]      w_disp_nxt;
    logic [1:0]       w_edit_sel_nxt;
    logic             w_ev_mode;
    logic             w_ev_ss;
    logic             w_ev_inc;
    logic             w_ev_tick;
    logic             w_any_btn;

    // Only the highest-priority event of a cycle is acted upon.
    assign w_ev_mode = i_btn_mode;
    assign w_ev_ss   = i_btn_start_stop & ~i_btn_mode;
    assign w_ev_inc  = i_btn_inc & ~i_btn_mode & ~i_btn_start_stop;
    assign w_any_btn = i_btn_mode | i_btn_start_stop | i_btn_inc;
    assign w_ev_tick = i_tick & ~w_any_btn;

    assign w_alarm_cnt_inc = r_alarm_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state, preset, count and alarm-counter logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_preset_nxt    = r_preset;
        w_count_nxt     = r_count;
        w_alarm_cnt_nxt = r_alarm_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_ev_mode) begin
                    w_state_nxt = ST_SET_MIN;
                end else if (w_ev_ss && (r_count != 14'd0)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SET_MIN: begin
                if (w_ev_mode) begin
                    w_state_nxt = ST_SET_SEC;
                end else if (w_ev_inc) begin
                    w_preset_nxt = {f_inc_field(r_preset[13:7]), r_preset[6:0]};
                end else begin
                    w_state_nxt = ST_SET_MIN;
                end
            end
            ST_SET_SEC: begin
                if (w_ev_mode) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = r_preset;
                end else if (w_ev_inc) begin
                    w_preset_nxt = {r_preset[13:7], f_inc_field(r_preset[6:0])};
                end else begin
                    w_state_nxt = ST_SET_SEC;
                end
            end
            ST_RUN: begin
                if (w_ev_mode) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = r_preset;
                end else if (w_ev_ss) begin
                    w_state_nxt = ST_PAUSE;
                end else if (w_ev_tick) begin
                    w_count_nxt = f_dec_time(r_count);
                    // Last second elapsing (or an already-empty count) expires.
                    if (r_count <= 14'd1) begin
                        w_state_nxt     = ST_EXPIRED;
                        w_alarm_cnt_nxt = {CNT_W{1'b0}};
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (w_ev_mode) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = r_preset;
                end else if (w_ev_ss) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_EXPIRED: begin
                if (w_any_btn) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = r_preset;
                end else if (w_ev_tick) begin
                    if (w_alarm_cnt_inc == LP_ALARM_TICKS) begin
                        w_state_nxt     = ST_IDLE;
                        w_count_nxt     = r_preset;
                        w_alarm_cnt_nxt = {CNT_W{1'b0}};
                    end else begin
                        w_alarm_cnt_nxt = w_alarm_cnt_inc;
                    end
                end else begin
                    w_state_nxt = ST_EXPIRED;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output values derived from the next state so they register alongside it.
    always_comb begin
        w_disp_nxt     = w_count_nxt;
        w_edit_sel_nxt = 2'b00;
        case (w_state_nxt)
            ST_SET_MIN: begin
                w_disp_nxt     = w_preset_nxt;
                w_edit_sel_nxt = 2'b01;
            end
            ST_SET_SEC: begin
                w_disp_nxt     = w_preset_nxt;
                w_edit_sel_nxt = 2'b10;
            end
            default: begin
                w_disp_nxt     = w_count_nxt;
                w_edit_sel_nxt = 2'b00;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_preset    <= 14'd0;
            r_count     <= 14'd0;
            r_alarm_cnt <= {CNT_W{1'b0}};
            r_disp      <= 14'd0;
            r_edit_sel  <= 2'b00;
            r_running   <= 1'b0;
            r_alarm     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_preset    <= w_preset_nxt;
            r_count     <= w_count_nxt;
            r_alarm_cnt <= w_alarm_cnt_nxt;
            r_disp      <= w_disp_nxt;
            r_edit_sel  <= w_edit_sel_nxt;
            r_running   <= (w_state_nxt == ST_RUN);
            r_alarm     <= (w_state_nxt == ST_EXPIRED);
        end
    end

    assign o_min_t    = r_disp[13:11];
    assign o_min_u    = r_disp[10:7];
    assign o_sec_t    = r_disp[6:4];
    assign o_sec_u    = r_disp[3:0];
    assign o_edit_sel = r_edit_sel;
    assign o_running  = r_running;
    assign o_alarm    = r_alarm;

endmodule

// File: tb/tb_countdown_ctrl.sv
module tb_countdown_ctrl;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       btn_mode;
    logic       btn_ss;
    logic       btn_inc;
    logic [3:0] sec_u;
    logic [2:0] sec_t;
    logic [3:0] min_u;
    logic [2:0] min_t;
    logic [1:0] edit_sel;
    logic       running;
    logic       alarm;

    int n_tests;
    int n_fail;

    countdown_ctrl #(.ALARM_TICKS(5), .CNT_W(4)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_tick           (tick),
        .i_btn_mode       (btn_mode),
        .i_btn_start_stop (btn_ss),
        .i_btn_inc        (btn_inc),
        .o_sec_u          (sec_u),
        .o_sec_t          (sec_t),
        .o_min_u          (min_u),
        .o_min_t          (min_t),
        .o_edit_sel       (edit_sel),
        .o_running        (running),
        .o_alarm          (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Display packed as hex-readable MM:SS, e.g. 02:03 -> 16'h0203.
    function automatic logic [15:0] disp();
        return {1'b0, min_t, min_u, 1'b0, sec_t, sec_u};
    endfunction

    // One clock with the given inputs held, then sample 1 ns after the edge.
    task automatic cyc(input logic r, input logic m, input logic s,
                       input logic i, input logic t);
        rst = r; btn_mode = m; btn_ss = s; btn_inc = i; tick = t;
        @(posedge clk);
        #1;
        rst = 1'b0; btn_mode = 1'b0; btn_ss = 1'b0; btn_inc = 1'b0; tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_rst();  cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); endtask
    task automatic do_mode(); cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
    task automatic do_ss();   cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
    task automatic do_tick(); cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); endtask
    task automatic do_inc(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0; btn_mode = 1'b0; btn_ss = 1'b0; btn_inc = 1'b0; tick = 1'b0;
        @(negedge clk);

        // Reset state
        do_rst();
        chk("rst_disp", disp(), 16'h0000);
        chk("rst_edit", {14'd0, edit_sel}, 16'd0);
        chk("rst_run",  {15'd0, running}, 16'd0);
        chk("rst_alarm", {15'd0, alarm}, 16'd0);

        // Preset entry 02:03
        do_mode();
        chk("set_min_edit", {14'd0, edit_sel}, 16'd1);
        do_inc(2);
        chk("set_min_disp", disp(), 16'h0200);
        do_mode();
        chk("set_sec_edit", {14'd0, edit_sel}, 16'd2);
        do_inc(3);
        chk("set_sec_disp", disp(), 16'h0203);
        do_mode();
        chk("idle_edit", {14'd0, edit_sel}, 16'd0);
        chk("idle_disp", disp(), 16'h0203);
        chk("idle_run",  {15'd0, running}, 16'd0);

        // Countdown 00:03 to expiry and alarm duration
        do_rst();
        do_mode(); do_mode(); do_inc(3); do_mode();
        chk("p3_disp", disp(), 16'h0003);
        do_ss();
        chk("p3_running", {15'd0, running}, 16'd1);
        do_tick();
        chk("p3_t1", disp(), 16'h0002);
        do_tick();
        chk("p3_t2", disp(), 16'h0001);
        chk("p3_t2_alarm", {15'd0, alarm}, 16'd0);
        do_tick();
        chk("p3_t3", disp(), 16'h0000);
        chk("p3_t3_alarm", {15'd0, alarm}, 16'd1);
        chk("p3_t3_run", {15'd0, running}, 16'd0);
        for (int k = 0; k < 4; k++) do_tick();
        chk("p3_alarm_4", {15'd0, alarm}, 16'd1);
        do_tick();
        chk("p3_alarm_5", {15'd0, alarm}, 16'd0);
        chk("p3_restore", disp(), 16'h0003);

        // Borrow 01:00 -> 00:59, then abort restores preset
        do_rst();
        do_mode(); do_inc(1); do_mode(); do_mode();
        do_ss();
        do_tick();
        chk("b100", disp(), 16'h0059);
        do_mode();
        chk("b100_abort", disp(), 16'h0100);
        chk("b100_abort_run", {15'd0, running}, 16'd0);

        // Borrow 10:00 -> 09:59
        do_rst();
        do_mode(); do_inc(10); do_mode(); do_mode();
        chk("b1000_preset", disp(), 16'h1000);
        do_ss();
        do_tick();
        chk("b1000", disp(), 16'h0959);

        // Pause with simultaneous tick, hold, resume
        do_rst();
        do_mode(); do_mode(); do_inc(10); do_mode();
        do_ss();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("pause_run", {15'd0, running}, 16'd0);
        chk("pause_disp", disp(), 16'h0010);
        for (int k = 0; k < 4; k++) do_tick();
        chk("pause_hold", disp(), 16'h0010);
        do_ss();
        chk("resume_run", {15'd0, running}, 16'd1);
        do_tick();
        chk("resume_tick", disp(), 16'h0009);

        // Minutes wrap 59 -> 00, seconds untouched
        do_rst();
        do_mode(); do_mode(); do_inc(3); do_mode();
        do_mode();
        do_inc(59);
        chk("wrap_59", disp(), 16'h5903);
        do_inc(1);
        chk("wrap_00", disp(), 16'h0003);

        // Start with empty count stays idle
        do_rst();
        do_ss();
        chk("zero_start_run", {15'd0, running}, 16'd0);
        chk("zero_start_disp", disp(), 16'h0000);

        // Reset mid-run clears everything including preset
        do_rst();
        do_mode(); do_mode(); do_inc(7); do_mode();
        do_ss();
        chk("r7_running", {15'd0, running}, 16'd1);
        do_rst();
        chk("r7_disp", disp(), 16'h0000);
        chk("r7_run", {15'd0, running}, 16'd0);
        chk("r7_alarm", {15'd0, alarm}, 16'd0);
        chk("r7_edit", {14'd0, edit_sel}, 16'd0);
        do_mode();
        chk("r7_preset", disp(), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
